// File: rtl/umem_arbiter.sv
// umem_arbiter: arbitrates one single-port unified memory between the
// instruction-fetch port (IF) and the data port (MEM) of the pipeline.
//
// Accesses are serialized by a four-state FSM (IDLE, BUSY_I, BUSY_D, RESP).
// The granted address, write enable and write data are latched at grant time,
// so requester inputs may change freely afterwards. Every memory transaction
// is bounded by TIMEOUT cycles of mem_req; an expired transaction completes
// with rdata = 0 and a one-cycle err pulse alongside the ack.
//
// Build option:
//   ARB_RR_EN  undefined: fixed priority, data port over fetch port.
//              defined:   round-robin between the two ports.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   if_req/if_addr      fetch request (level, held until if_ack) and PC
//   if_ack/if_rdata     fetch completion pulse and instruction
//   if_stall            if_req && !if_ack
//   d_req/d_we/d_addr/d_wdata  data request (level, held until d_ack)
//   d_ack/d_rdata       data completion pulse and load data
//   d_stall             d_req && !d_ack
//   mem_req/mem_we/mem_addr/mem_wdata  memory request side
//   mem_ack/mem_rdata   memory completion pulse and read data
//   busy                FSM not idle
//   err                 one-cycle pulse on timeout abort (with the ack)
module umem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              gnt_d_q, gnt_d_d;       // granted port is the data port
  logic              err_pend_q, err_pend_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
`ifdef ARB_RR_EN
  logic              last_d_q, last_d_d;     // 0 = fetch granted last
`endif

  logic if_elig, d_elig, pick_d;

  // A requester being acknowledged this cycle must not be re-granted.
  assign if_elig = if_req && !if_ack;
  assign d_elig  = d_req && !d_ack;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d_d     = gnt_d_q;
    err_pend_d  = err_pend_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef ARB_RR_EN
    last_d_d    = last_d_q;
    // On a tie the port not granted last wins.
    pick_d      = d_elig && (!if_elig || !last_d_q);
`else
    pick_d      = d_elig;
`endif

    unique case (state_q)
      StIdle: begin
        if (if_elig || d_elig) begin
          gnt_d_d     = pick_d;
          err_pend_d  = 1'b0;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = pick_d && d_we;
          mem_addr_d  = pick_d ? d_addr : if_addr;
          mem_wdata_d = pick_d ? d_wdata : mem_wdata_q;
          state_d     = pick_d ? StBusyD : StBusyI;
`ifdef ARB_RR_EN
          last_d_d    = pick_d;
`endif
        end
      end
      StBusyI, StBusyD: begin
        cnt_d = cnt_q + 1'b1;
        // mem_ack takes precedence over a timeout in the same cycle.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (state_q == StBusyI) begin
            if_rdata_d = mem_rdata;
          end else if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          err_pend_d = 1'b1;
          if (state_q == StBusyI) begin
            if_rdata_d = '0;
          end else if (!mem_we_q) begin
            d_rdata_d = '0;
          end
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      gnt_d_q     <= 1'b0;
      err_pend_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
`ifdef ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_d_q     <= gnt_d_d;
      err_pend_q  <= err_pend_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef ARB_RR_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  assign busy   = (state_q != StIdle);
  assign if_ack = (state_q == StResp) && !gnt_d_q;
  assign d_ack  = (state_q == StResp) && gnt_d_q;
  assign err    = (state_q == StResp) && err_pend_q;

  assign if_stall = if_req && !if_ack;
  assign d_stall  = d_req && !d_ack;

endmodule

// File: tb/tb_umem_arbiter.sv
// Self-checking bench for umem_arbiter (TIMEOUT = 4). A transaction-level
// model predicts, at each grant, the mem_req window, the ack/err cycle and
// the returned data; one compare process checks every cycle against it.
module tb_umem_arbiter;
  localparam int unsigned TO = 4;

  logic        clk, reset;
  logic        if_req, if_ack, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ack, d_stall;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack, busy, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 1;          // memory responds after lat cycles of mem_req
  bit spur = 0;         // drive mem_ack while mem_req is low
  int req_cycles = 0;
  int err_cnt = 0;

  umem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C080004;
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  assign mem_rdata = memval(mem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Memory responder.
  initial begin
    int rq;
    rq = 0;
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        mem_ack = (rq == lat);
        rq++;
      end else begin
        rq = 0;
        mem_ack = spur;
      end
    end
  end

  // Model and compare process.
  initial begin
    bit mv, act, m_isd, m_we, m_err, last_d;
    int g, n;
    logic [31:0] m_addr, m_wdata, e_ifr, e_dr;
    logic e_req, e_busy, e_ia, e_da, e_err;
    mv = 0; act = 0; last_d = 0; g = 0; n = 0;
    m_isd = 0; m_we = 0; m_err = 0; m_addr = 0; m_wdata = 0; e_ifr = 0; e_dr = 0;
    forever begin
      @(negedge clk);
      e_req  = act && (cyc >= g + 1) && (cyc <= g + n);
      e_busy = act && (cyc >= g + 1) && (cyc <= g + n + 1);
      e_ia   = act && (cyc == g + n + 1) && !m_isd;
      e_da   = act && (cyc == g + n + 1) && m_isd;
      e_err  = act && (cyc == g + n + 1) && m_err;
      if (act && cyc == g + n + 1) begin
        if (!m_isd) e_ifr = m_err ? 32'h0 : memval(m_addr);
        else if (!m_we) e_dr = m_err ? 32'h0 : memval(m_addr);
      end
      if (mv) begin
        chk("mem_req", {31'b0, mem_req}, {31'b0, e_req});
        chk("busy", {31'b0, busy}, {31'b0, e_busy});
        chk("if_ack", {31'b0, if_ack}, {31'b0, e_ia});
        chk("d_ack", {31'b0, d_ack}, {31'b0, e_da});
        chk("err", {31'b0, err}, {31'b0, e_err});
        chk("if_stall", {31'b0, if_stall}, {31'b0, if_req && !e_ia});
        chk("d_stall", {31'b0, d_stall}, {31'b0, d_req && !e_da});
        chk("if_rdata", if_rdata, e_ifr);
        chk("d_rdata", d_rdata, e_dr);
        if (e_req) begin
          chk("mem_addr", mem_addr, m_addr);
          chk("mem_we", {31'b0, mem_we}, {31'b0, m_we});
          if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
      end
      if (mem_req) req_cycles++;
      if (err) err_cnt++;
      if (reset) begin
        mv = 1; act = 0; e_ifr = 0; e_dr = 0; last_d = 0;
      end else if ((!act || cyc >= g + n + 2) && (if_req || d_req)) begin
        act = 1;
`ifdef ARB_RR_EN
        m_isd = d_req && (!if_req || !last_d);
        last_d = m_isd;
`else
        m_isd = d_req;
`endif
        g = cyc;
        m_we = m_isd && d_we;
        m_addr = m_isd ? d_addr : if_addr;
        m_wdata = d_wdata;
        if (lat <= int'(TO) - 1) begin
          n = lat + 1; m_err = 0;
        end else begin
          n = TO; m_err = 1;
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input bit scr, output int kack);
    bit got;
    got = 0; kack = -1;
    if_req = 1'b1; if_addr = a;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (if_ack) begin got = 1; kack = cyc; break; end
      if (scr && i == 1) begin @(posedge clk); #1; if_addr = ~a; end
    end
    if (!got) chk("if_ack_bound", 0, 1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic dop(input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input bit scr, output int kack);
    bit got;
    got = 0; kack = -1;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (d_ack) begin got = 1; kack = cyc; break; end
      if (scr && i == 1) begin @(posedge clk); #1; d_addr = ~a; d_wdata = ~wd; end
    end
    if (!got) chk("d_ack_bound", 0, 1);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  initial begin
    int t0, ka, ki, kd, na;
    bit seen;
    logic [3:0] ord;
    reset = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    @(posedge clk); #1;

    // Single fetch, scrambled address after grant.
    lat = 1; t0 = cyc;
    fetch(32'h40, 1, ka);
    chk("t1_latency", ka - t0, 3);
    chk("t1_rdata", if_rdata, 32'h8C080004);

    // Simultaneous: data store first, fetch 3 cycles after d_ack.
    lat = 0; t0 = cyc;
    fork
      fetch(32'h80, 0, ki);
      dop(1'b1, 32'h100, 32'hDEADBEEF, 0, kd);
      begin
        seen = 0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (mem_req) begin seen = 1; break; end
        end
        if (seen) begin
          chk("t2_first_we", {31'b0, mem_we}, 1);
          chk("t2_first_addr", mem_addr, 32'h100);
        end else chk("t2_req_bound", 0, 1);
      end
    join
    chk("t2_d_latency", kd - t0, 2);
    chk("t2_gap", ki - kd, 3);

    // Both ports busy for four grants.
    lat = 1;
    fork
      begin fetch(32'h84, 0, ki); fetch(32'h88, 0, ki); end
      begin dop(1'b1, 32'h180, 32'h12345678, 0, kd); dop(1'b0, 32'h184, 0, 0, kd); end
      begin
        na = 0; ord = 0;
        for (int i = 0; i < 80 && na < 4; i++) begin
          @(negedge clk);
          if (if_ack || d_ack) begin ord = {ord[2:0], d_ack}; na++; end
        end
      end
    join
`ifdef ARB_RR_EN
    chk("t3_order", {28'b0, ord}, 32'hA);
`else
    chk("t3_order", {28'b0, ord}, 32'hC);
`endif

    // Timeout on a load.
    lat = 99; req_cycles = 0; err_cnt = 0; t0 = cyc;
    dop(1'b0, 32'h200, 0, 0, kd);
    chk("t4_latency", kd - t0, TO + 1);
    chk("t4_req_cycles", req_cycles, TO);
    chk("t4_err_cnt", err_cnt, 1);
    chk("t4_rdata", d_rdata, 0);
    @(negedge clk);
    chk("t4_busy_after", {31'b0, busy}, 0);
    @(posedge clk); #1;

    // mem_ack on the last allowed cycle: normal completion.
    lat = TO - 1; err_cnt = 0; t0 = cyc;
    dop(1'b0, 32'h300, 32'h55, 1, kd);
    chk("t5_latency", kd - t0, TO + 1);
    chk("t5_rdata", d_rdata, 32'hA6C30300);
    chk("t5_err_cnt", err_cnt, 0);

    // Spurious mem_ack outside BUSY is ignored.
    spur = 1; lat = 2; t0 = cyc;
    fetch(32'h40, 0, ka);
    chk("t6_latency", ka - t0, 4);
    spur = 0;

    // Reset while in BUSY_D.
    lat = 99;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1; d_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t7_mem_req", {31'b0, mem_req}, 0);
    chk("t7_busy", {31'b0, busy}, 0);
    chk("t7_d_ack", {31'b0, d_ack}, 0);
    repeat (3) @(posedge clk);
    #1;
    lat = 1; t0 = cyc;
    fetch(32'h44, 0, ka);
    chk("t7_fetch_latency", ka - t0, 3);
    chk("t7_fetch_rdata", if_rdata, 32'hA5870044);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
